// File: rtl/ram_dump_tx.sv
// ram_dump_tx: reads words back from the line-organised main RAM and sends them out on a UART.
// On start_i (while idle) the engine fetches cache lines and transmits the requested words
// LSB-byte first, each byte as one 8N1 frame.
//
// Ports:
//   clk_i         core clock
//   rst_ni        synchronous active-low reset
//   start_i       begin dump (sampled only while idle)
//   start_addr_i  first word address
//   word_count_i  number of words to send (0 is legal)
//   busy_o        high while a dump is in progress
//   done_o        one-cycle pulse at the end of a dump
//   mem_addr_o    line-aligned word address to RAM
//   mem_rd_en_o   one-cycle read strobe per line
//   mem_rdata_i   RAM line data, valid the cycle after mem_rd_en_o
//   uart_tx_o     serial output, idles high
module ram_dump_tx #(
  parameter int unsigned CLK_FREQ         = 1_000_000,
  parameter int unsigned BAUD_RATE        = 100_000,
  parameter int unsigned ADDR_WIDTH       = 15,
  parameter int unsigned CACHE_LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH       = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [ADDR_WIDTH-1:0]       start_addr_i,
  input  logic [ADDR_WIDTH:0]         word_count_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic                        mem_rd_en_o,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_rdata_i,
  output logic                        uart_tx_o
);

  localparam int unsigned DIV            = CLK_FREQ / BAUD_RATE;
  localparam int unsigned DIV_W          = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned WORDS_PER_LINE = CACHE_LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned OFF_W          = $clog2(WORDS_PER_LINE);
  localparam int unsigned BYTES          = WORD_WIDTH / 8;
  localparam int unsigned BYTE_W         = $clog2(BYTES);

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StTxStart, StTxData, StTxStop, StNext, StDone
  } state_e;

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH:0]         remaining_q, remaining_d;
  logic [CACHE_LINE_WIDTH-1:0] linebuf_q, linebuf_d;
  logic [DIV_W-1:0]            baud_cnt_q, baud_cnt_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0]           byte_idx_q, byte_idx_d;
  logic                        busy_d, done_d, rd_en_d, tx_d;
  logic [ADDR_WIDTH-1:0]       mem_addr_d;
  logic [ADDR_WIDTH-1:0]       addr_inc;
  logic [OFF_W-1:0]            word_off;
  logic [WORD_WIDTH-1:0]       word_sel;
  logic [7:0]                  tx_byte;
  logic                        baud_done;

  assign word_off  = cur_addr_q[OFF_W-1:0];
  assign word_sel  = linebuf_q[word_off*WORD_WIDTH +: WORD_WIDTH];
  assign tx_byte   = word_sel[byte_idx_q*8 +: 8];
  assign baud_done = (baud_cnt_q == DIV_W'(DIV - 1));
  assign addr_inc  = cur_addr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    linebuf_d   = linebuf_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cur_addr_d  = start_addr_i;
          remaining_d = word_count_i;
          state_d     = (word_count_i == '0) ? StDone : StRdReq;
        end
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        linebuf_d  = mem_rdata_i;
        byte_idx_d = '0;
        baud_cnt_d = '0;
        state_d    = StTxStart;
      end
      StTxStart: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = StTxData;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      StTxData: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = StTxStop;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      StTxStop: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (byte_idx_q != BYTE_W'(BYTES - 1)) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = StTxStart;
          end else begin
            state_d = StNext;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      StNext: begin
        remaining_d = remaining_q - 1'b1;
        cur_addr_d  = addr_inc;
        byte_idx_d  = '0;
        baud_cnt_d  = '0;
        if (remaining_q == (ADDR_WIDTH+1)'(1))  state_d = StDone;
        // Offset wrapping to zero means the buffered line is used up (or the address wrapped).
        else if (addr_inc[OFF_W-1:0] == '0)     state_d = StRdReq;
        else                                    state_d = StTxStart;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    busy_d     = !(state_d inside {StIdle, StDone});
    done_d     = (state_d == StDone);
    rd_en_d    = (state_d == StRdReq);
    mem_addr_d = rd_en_d ? {cur_addr_d[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : mem_addr_o;
    unique case (state_d)
      StTxStart: tx_d = 1'b0;
      StTxData:  tx_d = tx_byte[bit_idx_d];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      linebuf_q   <= '0;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      mem_rd_en_o <= 1'b0;
      mem_addr_o  <= '0;
      uart_tx_o   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      linebuf_q   <= linebuf_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      mem_rd_en_o <= rd_en_d;
      mem_addr_o  <= mem_addr_d;
      uart_tx_o   <= tx_d;
    end
  end

endmodule

// File: tb/tb_ram_dump_tx.sv
// Bench for ram_dump_tx: directed dumps with hand-written expected bytes and read addresses
// queued at stimulus time; independent monitors decode the UART line and the RAM strobe.
module tb_ram_dump_tx;

  localparam int DIV = 10;
  localparam int AW  = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, rd_en, tx;
  logic [AW-1:0] mem_addr;
  logic [127:0]  mem_rdata = '0;

  ram_dump_tx #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .ADDR_WIDTH(AW),
    .CACHE_LINE_WIDTH(128), .WORD_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .start_addr_i(start_addr),
    .word_count_i(word_count), .busy_o(busy), .done_o(done), .mem_addr_o(mem_addr),
    .mem_rd_en_o(rd_en), .mem_rdata_i(mem_rdata), .uart_tx_o(tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rd_cnt   = 0;
  logic [7:0]    exp_bytes[$];
  logic [AW-1:0] exp_addrs[$];
  int            fstart[$];
  logic [31:0]   mem [0:32767];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_bytes.push_back(w[7:0]);
    exp_bytes.push_back(w[15:8]);
    exp_bytes.push_back(w[23:16]);
    exp_bytes.push_back(w[31:24]);
  endtask

  initial forever @(posedge clk) cyc++;

  // RAM model: line data appears the cycle after the read strobe.
  initial forever @(posedge clk) begin
    if (rd_en) begin
      for (int k = 0; k < 4; k++) mem_rdata[k*32 +: 32] <= mem[(int'(mem_addr) + k) % 32768];
    end
  end

  // RAM strobe monitor.
  initial forever @(negedge clk) begin
    if (rst_n && rd_en) begin
      rd_cnt++;
      if (exp_addrs.size() == 0) check("rd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
      else check("rd_addr", 32'(mem_addr), 32'(exp_addrs.pop_front()));
    end
  end

  // done_o monitor: pulse must be one cycle wide and busy low alongside it.
  initial begin
    logic prev = 1'b0;
    forever @(negedge clk) begin
      if (rst_n && done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_width", 32'(prev), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
      end
      prev = rst_n && done;
    end
  end

  // UART receiver: every cycle of each bit must hold the value seen at the bit's first cycle.
  initial begin
    bit       rx_busy = 0;
    int       rx_t = 0;
    logic     rx_bit = 1'b1;
    bit       rx_bad = 0;
    logic [7:0] rx_byte = '0;
    forever @(negedge clk) begin
      if (!rst_n) begin
        rx_busy = 0;
      end else begin
        if (!rx_busy) begin
          if (tx == 1'b0) begin
            rx_busy = 1; rx_t = 0; rx_bad = 0;
            fstart.push_back(cyc);
          end
        end else begin
          rx_t++;
        end
        if (rx_busy) begin
          if (rx_t % DIV == 0) begin
            rx_bit = tx;
            if (rx_t / DIV >= 1 && rx_t / DIV <= 8) rx_byte[rx_t/DIV - 1] = tx;
          end else if (tx !== rx_bit) begin
            rx_bad = 1;
          end
          if (rx_t == 10*DIV - 1) begin
            check("frame_shape", {30'd0, rx_bad, rx_bit}, 32'd1);
            if (exp_bytes.size() == 0) check("byte_unexpected", 32'(rx_byte), 32'hFFFF_FFFF);
            else check("byte", 32'(rx_byte), 32'(exp_bytes.pop_front()));
            rx_busy = 0;
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] n, output int s_cyc);
    @(negedge clk);
    s_cyc = cyc;
    start = 1'b1; start_addr = a; word_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int i = 0;
    while (done_cnt == base && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("done_timeout", 32'(done_cnt > base), 32'd1);
  endtask

  task automatic end_test(input int d_base, input int r_base, input int n_rd);
    repeat (3) @(negedge clk);
    check("bytes_left", 32'(exp_bytes.size()), 32'd0);
    check("addrs_left", 32'(exp_addrs.size()), 32'd0);
    check("done_count", 32'(done_cnt - d_base), 32'd1);
    check("rd_count", 32'(rd_cnt - r_base), 32'(n_rd));
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_tx", 32'(tx), 32'd1);
  endtask

  initial begin
    int s, d0, r0, f0;
    bit tx_low, busy_hi;
    for (int i = 0; i < 32768; i++) mem[i] = {16'hA5A5, 16'(i)};
    mem[15'h000E] = 32'h1122_3344;
    mem[15'h000F] = 32'h5566_7788;
    mem[15'h0010] = 32'hDEAD_BEEF;
    mem[15'h0011] = 32'h0BAD_F00D;
    mem[15'h7FFF] = 32'hCAFE_BABE;
    mem[15'h0000] = 32'h1234_5678;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single word with frame timing.
    d0 = done_cnt; r0 = rd_cnt; f0 = fstart.size();
    push_word(32'hDEAD_BEEF); exp_addrs.push_back(15'h0010);
    pulse_start(15'h0010, 16'd1, s);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(d0, 2000);
    end_test(d0, r0, 1);
    check("frames_t1", 32'(fstart.size() - f0), 32'd4);
    if (fstart.size() - f0 == 4) begin
      for (int k = 1; k < 4; k++)
        check("frame_spacing", 32'(fstart[f0+k] - fstart[f0+k-1]), 32'(10*DIV));
      check("done_after_stop",
            32'(done_cyc - fstart[f0+3] == 10*DIV || done_cyc - fstart[f0+3] == 10*DIV + 1),
            32'd1);
    end

    // 2: line crossing.
    d0 = done_cnt; r0 = rd_cnt; f0 = fstart.size();
    push_word(32'h1122_3344); push_word(32'h5566_7788);
    push_word(32'hDEAD_BEEF); push_word(32'h0BAD_F00D);
    exp_addrs.push_back(15'h000C); exp_addrs.push_back(15'h0010);
    pulse_start(15'h000E, 16'd4, s);
    wait_done(d0, 5000);
    end_test(d0, r0, 2);
    check("frames_t2", 32'(fstart.size() - f0), 32'd16);

    // 3: zero count.
    d0 = done_cnt; r0 = rd_cnt;
    tx_low = 0; busy_hi = 0;
    pulse_start(15'h0123, 16'd0, s);
    repeat (4) begin
      if (tx == 1'b0) tx_low = 1;
      if (busy) busy_hi = 1;
      @(negedge clk);
    end
    check("zero_tx_low", 32'(tx_low), 32'd0);
    check("zero_busy", 32'(busy_hi), 32'd0);
    check("zero_done_lat", 32'(done_cyc - s >= 1 && done_cyc - s <= 2), 32'd1);
    end_test(d0, r0, 0);

    // 4: address wrap.
    d0 = done_cnt; r0 = rd_cnt;
    push_word(32'hCAFE_BABE); push_word(32'h1234_5678);
    exp_addrs.push_back(15'h7FFC); exp_addrs.push_back(15'h0000);
    pulse_start(15'h7FFF, 16'd2, s);
    wait_done(d0, 3000);
    end_test(d0, r0, 2);

    // 5: start while busy is ignored.
    d0 = done_cnt; r0 = rd_cnt; f0 = fstart.size();
    push_word(32'hDEAD_BEEF); exp_addrs.push_back(15'h0010);
    pulse_start(15'h0010, 16'd1, s);
    repeat (60) @(negedge clk);
    pulse_start(15'h000E, 16'd4, s);
    wait_done(d0, 2000);
    repeat (20) @(negedge clk);
    end_test(d0, r0, 1);
    check("frames_t5", 32'(fstart.size() - f0), 32'd4);

    // 6: reset mid-dump, then a clean dump.
    d0 = done_cnt; r0 = rd_cnt; f0 = fstart.size();
    exp_addrs.push_back(15'h0010);
    pulse_start(15'h0011, 16'd1, s);
    for (int i = 0; i < 100 && fstart.size() == f0; i++) @(negedge clk);
    check("t6_frame_seen", 32'(fstart.size() > f0), 32'd1);
    repeat (35) @(negedge clk);
    check("t6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    exp_bytes.delete();
    @(negedge clk);
    check("t6_rst_tx", 32'(tx), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt; r0 = rd_cnt; f0 = fstart.size();
    push_word(32'h1122_3344); exp_addrs.push_back(15'h000C);
    pulse_start(15'h000E, 16'd1, s);
    wait_done(d0, 2000);
    end_test(d0, r0, 1);
    check("frames_t6", 32'(fstart.size() - f0), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
